// File: rtl/rf_pkg.sv
// Shared types and constants for the multiport register file and its dump engine.
package rf_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DUMP,
      DONE
   } dump_state_t;

   localparam int unsigned LANE_A    = 0;
   localparam int unsigned LANE_B    = 1;
   localparam int unsigned DEF_DW    = 16;
   localparam int unsigned DEF_DEPTH = 16;

endpackage

// File: rtl/rf_dump_fsm.sv
// Serial register dump engine: on halt, streams registers 1..DEPTH-1 out of the debug port.
// Defining RF_BYPASS_EN also prints each beat in simulation.
module rf_dump_fsm
   import rf_pkg::*;
#(
   parameter int unsigned DW    = DEF_DW,
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hlt,
   output logic [AW-1:0] rd_idx,
   input  logic [DW-1:0] rd_val,
   output logic          dump_vld,
   output logic [AW-1:0] dump_idx,
   output logic [DW-1:0] dump_data,
   output logic          dump_done
);

   localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

   dump_state_t   state_q, state_d;
   logic          vld_q, vld_d;
   logic          done_q, done_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [DW-1:0] data_q, data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
         idx_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         vld_q   <= vld_d;
         done_q  <= done_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (hlt) state_d = DUMP;
         DUMP:    if (idx_q == LastIdx) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // The index counter is the registered beat index; the array is probed one ahead.
   assign rd_idx = (state_q == IDLE) ? AW'(1) : idx_q + AW'(1);

   always_comb begin
      vld_d  = 1'b0;
      done_d = done_q;
      idx_d  = idx_q;
      data_d = data_q;
      case (state_q)
         IDLE: begin
            if (hlt) begin
               vld_d  = 1'b1;
               idx_d  = rd_idx;
               data_d = rd_val;
            end
         end
         DUMP: begin
            if (idx_q == LastIdx) begin
               done_d = 1'b1;
            end else begin
               vld_d  = 1'b1;
               idx_d  = rd_idx;
               data_d = rd_val;
            end
         end
         DONE:    done_d = 1'b1;
         default: done_d = 1'b0;
      endcase
   end

   assign dump_vld  = vld_q;
   assign dump_idx  = idx_q;
   assign dump_data = data_q;
   assign dump_done = done_q;

`ifdef RF_BYPASS_EN
   always @(posedge clk) begin
      if (vld_q) $display("R%h = %h", idx_q, data_q);
   end
`endif

endmodule

// File: rtl/rf_multiport.sv
// Multiport register file: NUM_RD registered read ports, two write lanes, r0 hardwired to zero.
// RF_BYPASS_EN forwards same-cycle write data to the read ports (lane B over lane A).
module rf_multiport
   import rf_pkg::*;
#(
   parameter int unsigned DW     = DEF_DW,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned AW     = $clog2(DEPTH),
   parameter int unsigned NUM_RD = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_RD-1:0]    rd_en,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD*DW-1:0] rd_data,
   input  logic [1:0]           wr_en,
   input  logic [2*AW-1:0]      wr_addr,
   input  logic [2*DW-1:0]      wr_data,
   input  logic                 hlt,
   output logic                 dump_vld,
   output logic [AW-1:0]        dump_idx,
   output logic [DW-1:0]        dump_data,
   output logic                 dump_done
);

   logic [DW-1:0]       mem_q [DEPTH];
   logic [DW-1:0]       rd_val [NUM_RD];
   logic [NUM_RD*DW-1:0] rd_data_q;
   logic [AW-1:0]       dump_rd_idx;

   logic [AW-1:0] wa_a, wa_b;
   logic [DW-1:0] wd_a, wd_b;
   logic          we_a, we_b;

   assign wa_a = wr_addr[LANE_A*AW +: AW];
   assign wa_b = wr_addr[LANE_B*AW +: AW];
   assign wd_a = wr_data[LANE_A*DW +: DW];
   assign wd_b = wr_data[LANE_B*DW +: DW];
   assign we_a = wr_en[LANE_A] && (wa_a != '0);
   assign we_b = wr_en[LANE_B] && (wa_b != '0);

   // Lane B is applied last so it wins a same-address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (we_a) mem_q[wa_a] <= wd_a;
         if (we_b) mem_q[wa_b] <= wd_b;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         rd_val[i] = mem_q[rd_addr[i*AW +: AW]];
`ifdef RF_BYPASS_EN
         if (we_a && (rd_addr[i*AW +: AW] == wa_a)) rd_val[i] = wd_a;
         if (we_b && (rd_addr[i*AW +: AW] == wa_b)) rd_val[i] = wd_b;
`endif
         if (rd_addr[i*AW +: AW] == '0) rd_val[i] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         for (int i = 0; i < NUM_RD; i++) begin
            if (rd_en[i]) rd_data_q[i*DW +: DW] <= rd_val[i];
         end
      end
   end

   assign rd_data = rd_data_q;

   rf_dump_fsm #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_dump (
      .clk       (clk),
      .rst_n     (rst_n),
      .hlt       (hlt),
      .rd_idx    (dump_rd_idx),
      .rd_val    (mem_q[dump_rd_idx]),
      .dump_vld  (dump_vld),
      .dump_idx  (dump_idx),
      .dump_data (dump_data),
      .dump_done (dump_done)
   );

endmodule

// File: tb/tb_rf_multiport.sv
// Randomised self-checking bench for rf_multiport against an array-based reference model.
module tb_rf_multiport;

   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int NRD   = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NRD-1:0]    rd_en = '0;
   logic [NRD*AW-1:0] rd_addr = '0;
   logic [NRD*DW-1:0] rd_data;
   logic [1:0]        wr_en = '0;
   logic [2*AW-1:0]   wr_addr = '0;
   logic [2*DW-1:0]   wr_data = '0;
   logic              hlt = 1'b0;
   logic              dump_vld;
   logic [AW-1:0]     dump_idx;
   logic [DW-1:0]     dump_data;
   logic              dump_done;

   rf_multiport #(
      .DW     (DW),
      .DEPTH  (DEPTH),
      .NUM_RD (NRD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .hlt       (hlt),
      .dump_vld  (dump_vld),
      .dump_idx  (dump_idx),
      .dump_data (dump_data),
      .dump_done (dump_done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0] model [DEPTH];
   logic [DW-1:0] exp_rd [NRD];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Value a read of address a returns this cycle, given the writes being applied.
   function automatic logic [DW-1:0] ref_read(input int a);
      if (a == 0) return '0;
`ifdef RF_BYPASS_EN
      if (wr_en[1] && int'(wr_addr[AW +: AW]) == a) return wr_data[DW +: DW];
      if (wr_en[0] && int'(wr_addr[0 +: AW]) == a) return wr_data[0 +: DW];
`endif
      return model[a];
   endfunction

   task automatic cycle();
      logic [DW-1:0] nxt [NRD];
      for (int i = 0; i < NRD; i++)
         nxt[i] = rd_en[i] ? ref_read(int'(rd_addr[i*AW +: AW])) : exp_rd[i];
      for (int k = 0; k < 2; k++)
         if (wr_en[k] && wr_addr[k*AW +: AW] != 0) model[wr_addr[k*AW +: AW]] = wr_data[k*DW +: DW];
      for (int i = 0; i < NRD; i++) exp_rd[i] = nxt[i];
      @(posedge clk);
      #1;
      check("rd0", {16'h0, rd_data[0 +: DW]}, {16'h0, exp_rd[0]});
      check("rd1", {16'h0, rd_data[DW +: DW]}, {16'h0, exp_rd[1]});
   endtask

   task automatic idle();
      rd_en = '0;
      wr_en = '0;
   endtask

   task automatic write1(input int a, input logic [DW-1:0] d);
      wr_en = 2'b01;
      wr_addr = {4'h0, 4'(a)};
      wr_data = {16'h0, d};
      cycle();
      wr_en = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      hlt = 1'b0;
      idle();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      for (int i = 0; i < NRD; i++) exp_rd[i] = '0;
      #1;
      check("rst_rd", {16'h0, rd_data}, 32'h0);
      check("rst_vld", {31'h0, dump_vld}, 32'h0);
      check("rst_done", {31'h0, dump_done}, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Fill r1..r15 with idx*0x11, raise hlt and follow the beats; stop_at>0 resets at that beat.
   task automatic run_dump(input int stop_at);
      idle();
      for (int r = 1; r < DEPTH; r++) write1(r, 16'(r * 'h11));
      hlt = 1'b1;
      cycle();
      for (int k = 1; k < DEPTH; k++) begin
         check("dump_vld", {31'h0, dump_vld}, 32'h1);
         check("dump_idx", {28'h0, dump_idx}, k);
         check("dump_data", {16'h0, dump_data}, k * 'h11);
         check("dump_done_early", {31'h0, dump_done}, 32'h0);
         if (k == stop_at) begin
            do_reset();
            return;
         end
         cycle();
      end
      check("done_vld", {31'h0, dump_vld}, 32'h0);
      check("done_flag", {31'h0, dump_done}, 32'h1);
      hlt = 1'b0;
      repeat (3) cycle();
      check("done_sticky", {31'h0, dump_done}, 32'h1);
      check("done_sticky_vld", {31'h0, dump_vld}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // Every address reads zero after reset.
      for (int a = 0; a < DEPTH; a++) begin
         rd_en = 2'b11;
         rd_addr = {4'(a), 4'(a)};
         cycle();
         check("t1_zero", {16'h0, rd_data[0 +: DW]}, 32'h0);
      end
      idle();

      // r0 hardwired.
      write1(0, 16'hBEEF);
      rd_en = 2'b01; rd_addr = 8'h00; cycle();
      check("t2_r0", {16'h0, rd_data[0 +: DW]}, 32'h0);
      idle();
      write1(5, 16'h1234);
      rd_en = 2'b01; rd_addr = 8'h05; cycle();
      check("t2_r5", {16'h0, rd_data[0 +: DW]}, 32'h1234);

      // Lane collision.
      idle();
      wr_en = 2'b11; wr_addr = 8'h77; wr_data = 32'hBBBB_AAAA; cycle();
      idle();
      rd_en = 2'b10; rd_addr = 8'h70; cycle();
      check("t3_collide", {16'h0, rd_data[DW +: DW]}, 32'hBBBB);

      // Same-cycle write and read.
      idle();
      write1(3, 16'h0001);
      wr_en = 2'b01; wr_addr = 8'h03; wr_data = 32'h0000_5A5A;
      rd_en = 2'b01; rd_addr = 8'h03; cycle();
`ifdef RF_BYPASS_EN
      check("t4_same", {16'h0, rd_data[0 +: DW]}, 32'h5A5A);
`else
      check("t4_same", {16'h0, rd_data[0 +: DW]}, 32'h0001);
`endif
      wr_en = '0; cycle();
      check("t4_after", {16'h0, rd_data[0 +: DW]}, 32'h5A5A);

      // Read-enable hold.
      idle();
      write1(2, 16'h0022);
      rd_en = 2'b10; rd_addr = 8'h20; cycle();
      check("t5_read", {16'h0, rd_data[DW +: DW]}, 32'h0022);
      rd_en = 2'b00; wr_en = 2'b01; wr_addr = 8'h02; wr_data = 32'h0000_9999; cycle();
      idle(); cycle();
      check("t5_hold", {16'h0, rd_data[DW +: DW]}, 32'h0022);

      // Randomised traffic, with forced lane collisions and read-after-write hazards.
      for (int n = 0; n < 400; n++) begin
         rd_en = 2'($urandom);
         wr_en = 2'($urandom);
         wr_addr = 8'($urandom);
         wr_data = $urandom;
         if ($urandom_range(3) == 0) wr_addr[AW +: AW] = wr_addr[0 +: AW];
         rd_addr = 8'($urandom);
         if ($urandom_range(2) == 0) rd_addr[0 +: AW] = wr_addr[$urandom_range(1) * AW +: AW];
         cycle();
      end

      run_dump(5);
      check("mid_rst_done", {31'h0, dump_done}, 32'h0);
      check("mid_rst_vld", {31'h0, dump_vld}, 32'h0);
      run_dump(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
Parametrised, fully synchronous register file for the pipelined core. It has NUM_RD read ports and two write ports (WB and a second writeback lane), with register 0 hardwired to zero. Read data is registered. On halt, a serial dump state machine streams every register's contents out of a debug port.

Parameters:
DW, 16, data width in bits
DEPTH, 16, number of registers; power of two, at least 4
AW, $clog2(DEPTH), address width (derived; do not override)
NUM_RD, 2, number of read ports, 1 to 4

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*AW  packed read addresses; port i at [i*AW +: AW]
rd_data  out  NUM_RD*DW  packed registered read data
wr_en  in  2  write enables; bit 0 = lane A, bit 1 = lane B
wr_addr  in  2*AW  packed write addresses
wr_data  in  2*DW  packed write data
hlt  in  1  halt request; level
dump_vld  out  1  dump beat valid
dump_idx  out  AW  register index of the current beat
dump_data  out  DW  register contents of the current beat
dump_done  out  1  sticky; high after the last beat

Behaviour:
- Reset (async assert, sync deassert is the parent's job): all registers, rd_data, dump_* and the FSM go to 0 / IDLE.
- Register 0 always reads 0. Writes to address 0 are dropped.
- Write: on the clk edge, when wr_en[k] is set and wr_addr[k] != 0, mem[wr_addr[k]] <= wr_data[k].
- Write collision (both lanes, same address): lane B wins.
- Read: 1-cycle latency. On the edge, when rd_en[i]=1, rd_data[i] <= value of mem[rd_addr[i]] (bypass rules below). When rd_en[i]=0, rd_data[i] holds its previous value.
- Out-of-range addresses cannot occur because DEPTH is a power of two.
- Dump FSM states: IDLE, DUMP, DONE.
  - IDLE->DUMP on the first cycle hlt=1. Index counter starts at 1.
  - DUMP: each cycle, dump_vld=1, dump_idx=cnt, dump_data=mem[cnt]; then cnt++.
  - DUMP->DONE after the beat with cnt=DEPTH-1 (DEPTH-1 beats, registers 1..DEPTH-1).
  - DONE: dump_vld=0, dump_done=1. Stays in DONE until reset; deasserting hlt has no effect.
  - Writes arriving during DUMP still commit. A beat reflects the array contents at the start of that cycle (no bypass on the dump path).
  - dump_vld, dump_idx and dump_data are registered outputs. The first beat appears the cycle after hlt is sampled high.
- Reset mid-dump: the FSM returns to IDLE, dump_done clears, and the dump restarts on the next hlt.
- When RF_BYPASS_EN is defined, the simulation-only $display dump ("R%h = %h") is emitted per beat; the display contains no logic.

Optional Feature:
RF_BYPASS_EN
- Defined: a read that hits a same-cycle write address returns the new write data, with lane B taking priority over lane A. The write-then-read hazard is hidden from the pipeline, and the $display per dump beat is enabled.
- Undefined: the read returns the pre-write array value (old data). Forwarding is the pipeline's job. No $display.
- Address 0 is never bypassed in either case.

Decomposition:
- Package rf_pkg holds:
  - the dump_state_t enum (IDLE, DUMP, DONE);
  - the LANE_A and LANE_B index constants;
  - the default DW/DEPTH localparams.
- One natural sub-module, rf_dump_fsm: holds the state, the counter and the dump_* registers, and reads the array through an index/data pair. The array and read ports stay in rf_multiport.

Test Plan:
1. Reset then read all addresses: rst_n low for 2 cycles, then read addresses 0..15 -> rd_data=0 on every port, 1 cycle after each rd_en.
2. Register 0 is hardwired: write 0xBEEF to addr 0, then read addr 0 -> 0x0000. Write 0x1234 to addr 5, then read it the next cycle -> 0x1234.
3. Lane collision: lane A writes 0xAAAA and lane B writes 0xBBBB to addr 7 in the same cycle. Read addr 7 next cycle -> 0xBBBB.
4. Same-cycle write and read: write 0x5A5A to addr 3 (old value 0x0001) while reading addr 3 in the same cycle.
   - With RF_BYPASS_EN: rd_data=0x5A5A.
   - Without it: rd_data=0x0001, then 0x5A5A on the next read.
5. Read enable hold: port 1 reads addr 2 (0x0022), then rd_en[1]=0 while addr 2 is rewritten to 0x9999 -> rd_data[1] stays 0x0022.
6. Dump: registers 1..15 hold index*0x11, then hlt=1.
   - Expect 15 consecutive dump_vld beats, idx 1..15, data 0x0011..0x00FF, then dump_done=1 and dump_vld=0.
   - Assert rst_n low at beat 5: FSM returns to IDLE with dump_done=0. Re-raising hlt restarts the dump at idx 1.
